// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch sequencer for the RV32 core. Owns the program counter,
// issues one outstanding word request at a time to instruction memory over a
// req/ack handshake, and buffers returned instructions (tagged with their PC)
// in a small registered FIFO toward decode. Branch/trap redirects flush the
// FIFO and restart fetch; a fetch already in flight when a redirect arrives
// is completed on the bus but its data is thrown away. A wrapping counter
// tracks every fetch whose data was actually kept.
//
// Ports:
//   clk             core clock
//   rst_n           asynchronous active-low reset
//   mem_req_o       fetch request (high while a request is outstanding)
//   mem_addr_o      word-aligned fetch address, stable until the ack cycle
//   mem_ack_i       request accepted, mem_rdata_i valid this cycle
//   mem_rdata_i     fetched instruction word
//   redirect_i      flush and restart at redirect_addr_i
//   redirect_addr_i new PC (low two bits ignored)
//   if_valid_o      FIFO head valid
//   if_instr_o      head instruction (0 when empty)
//   if_pc_o         head PC (0 when empty)
//   if_ready_i      decode consumes the head when if_valid_o & if_ready_i
//   fetch_cnt_o     number of accepted (non-squashed) fetches, wrapping
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   IF_BASE_ADDR = 32'h1000_0000,
  parameter logic [XLEN-1:0]   IF_MAX_ADDR  = 32'h1000_3FFF,
  parameter int unsigned       IF_INC       = 4,
  parameter int unsigned       FIFO_DEPTH   = 2,
  parameter int unsigned       PERF_CNT_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    mem_req_o,
  output logic [XLEN-1:0]         mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic [XLEN-1:0]         mem_rdata_i,
  input  logic                    redirect_i,
  input  logic [XLEN-1:0]         redirect_addr_i,
  output logic                    if_valid_o,
  output logic [XLEN-1:0]         if_instr_o,
  output logic [XLEN-1:0]         if_pc_o,
  input  logic                    if_ready_i,
  output logic [PERF_CNT_LEN-1:0] fetch_cnt_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // FETCH keeps the data of the outstanding request, FLUSH discards it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]         pc_q;
  logic [XLEN-1:0]         tgt_q;
  logic [PERF_CNT_LEN-1:0] fetch_cnt_q;

  logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occ_after;
  logic             space_ok;
  logic [XLEN-1:0]  redirect_tgt;
  logic [XLEN:0]    pc_inc;
  logic [XLEN-1:0]  pc_seq;

  // ---------------------------------------------------------------------
  // Shared combinational helpers
  // ---------------------------------------------------------------------

  // Redirect targets are forced to a word boundary; no range check.
  assign redirect_tgt = redirect_addr_i & ~XLEN'(3);

  // Sequential successor computed one bit wider so that an address near the
  // top of the 32-bit space also wraps back to the base instead of rolling
  // over to a small value.
  assign pc_inc = {1'b0, pc_q} + (XLEN+1)'(IF_INC);
  assign pc_seq = (pc_inc > {1'b0, IF_MAX_ADDR}) ? IF_BASE_ADDR : pc_inc[XLEN-1:0];

  // Only a kept fetch pushes; an ack that coincides with a redirect is dropped.
  assign push = (state_q == ST_FETCH) && mem_ack_i && !redirect_i;
  assign pop  = if_valid_o && if_ready_i;

  // Occupancy after this edge decides whether another request may go out.
  // A redirect empties the FIFO, so space is always available after one.
  assign occ_after = redirect_i ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
  assign space_ok  = (occ_after < CNT_W'(FIFO_DEPTH));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (space_ok) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // With an ack the request completes; keep streaming only while the
        // FIFO can still absorb another word. Without an ack a redirect
        // cannot cancel the bus request, so it is turned into a flush.
        if (mem_ack_i) begin
          state_d = space_ok ? ST_FETCH : ST_IDLE;
        end else if (redirect_i) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (mem_ack_i) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mem_req_o = 1'b0;
    unique case (state_q)
      ST_FETCH, ST_FLUSH: mem_req_o = 1'b1;
      default:            mem_req_o = 1'b0;
    endcase
  end

  assign mem_addr_o = pc_q;

  // ---------------------------------------------------------------------
  // PC and latched redirect target.
  // The PC only moves when no request is outstanding or on the ack cycle,
  // which keeps mem_addr_o stable for the whole handshake. A redirect that
  // arrives mid-request parks its target in tgt_q (last one wins) until the
  // squashed request finishes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= IF_BASE_ADDR;
      tgt_q <= IF_BASE_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (redirect_i) begin
            pc_q <= redirect_tgt;
          end
        end
        ST_FETCH: begin
          if (mem_ack_i) begin
            pc_q <= redirect_i ? redirect_tgt : pc_seq;
          end else if (redirect_i) begin
            tgt_q <= redirect_tgt;
          end
        end
        ST_FLUSH: begin
          if (mem_ack_i) begin
            pc_q <= redirect_i ? redirect_tgt : tgt_q;
          end else if (redirect_i) begin
            tgt_q <= redirect_tgt;
          end
        end
        default: begin
          pc_q <= pc_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Accepted-fetch counter, wraps naturally at its width.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
    end else if (push) begin
      fetch_cnt_q <= fetch_cnt_q + PERF_CNT_LEN'(1);
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy. Depth is a power of two so the pointers
  // wrap on their own. A redirect wins over a same-cycle pop: whatever was
  // popped is consumed and the FIFO simply ends up empty.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are don't-care while the slot is not occupied,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= pc_q;
      fifo_instr[wr_ptr_q] <= mem_rdata_i;
    end
  end

  // Head outputs are forced to zero when empty so stale slots never leak.
  assign if_valid_o = (count_q != '0);
  assign if_instr_o = if_valid_o ? fifo_instr[rd_ptr_q] : '0;
  assign if_pc_o    = if_valid_o ? fifo_pc[rd_ptr_q]    : '0;

  // The space rule must make a push into a full, non-draining FIFO impossible.
`ifndef SYNTHESIS
  fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((count_q < CNT_W'(FIFO_DEPTH)) || pop));
`endif

endmodule
